pipe_hazard_ctrl: RTL and testbench

// - Central stall/flush scheduler for the 5-stage pipeline. Drives the nop (hold) inputs of the
//   if_id, id_ex, ex_mem, mem_wb latches, the PC hold, and bubble-insert (flush) for IF/ID, ID/EX.
// - Resolves load-use, branch redirect, I-mem and D-mem busy, and halt, in one priority order.

---
 rtl/pipe_hazard_ctrl.sv | 168 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: load-use, branch redirect, memory busy, halt.
// Optional perf counters are built when PIPE_HAZARD_PERF_EN is defined; otherwise tied to zero.
module pipe_hazard_ctrl #(
    parameter int REG_W       = 3,
    parameter int BOOT_CYCLES = 2,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_memread,
    input  logic             ex_br_taken,
    input  logic             imem_busy,
    input  logic             dmem_busy,
    input  logic             m_halt,
    output logic             pc_hold,
    output logic             hold_fd,
    output logic             hold_de,
    output logic             hold_em,
    output logic             hold_mw,
    output logic             flush_fd,
    output logic             flush_de,
    output logic             halted,
    output logic             err_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {BOOT, RUN, MEM_WAIT, HALTED} state_t;

    localparam int BW = $clog2(BOOT_CYCLES + 1);
    localparam int WW = $clog2(MEM_TIMEOUT + 1);

    state_t          state_q, state_d;
    logic [BW-1:0]   boot_cnt_q, boot_cnt_d;
    logic [WW-1:0]   wait_cnt_q, wait_cnt_d;
    logic            err_q, err_d;
    logic            load_use;
    logic            hold_fd_raw, hold_de_raw;

    assign load_use = ex_memread &
                      ((id_use_rs & (id_rs == ex_rd)) | (id_use_rt & (id_rt == ex_rd)));

    always_comb begin
        state_d     = state_q;
        boot_cnt_d  = boot_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        err_d       = err_q;
        pc_hold     = 1'b0;
        hold_fd_raw = 1'b0;
        hold_de_raw = 1'b0;
        hold_em     = 1'b0;
        hold_mw     = 1'b0;
        flush_fd    = 1'b0;
        flush_de    = 1'b0;
        halted      = 1'b0;
        case (state_q)
            BOOT: begin
                pc_hold  = 1'b1;
                flush_fd = 1'b1;
                if (boot_cnt_q == BW'(BOOT_CYCLES - 1)) state_d = RUN;
                else                                    boot_cnt_d = boot_cnt_q + 1'b1;
            end
            RUN, MEM_WAIT: begin
                if (dmem_busy) begin
                    pc_hold     = 1'b1;
                    hold_fd_raw = 1'b1;
                    hold_de_raw = 1'b1;
                    hold_em     = 1'b1;
                    hold_mw     = 1'b1;
                    if (state_q == RUN) begin
                        state_d    = MEM_WAIT;
                        wait_cnt_d = WW'(1);
                    end else if (wait_cnt_q + 1'b1 >= WW'(MEM_TIMEOUT)) begin
                        err_d   = 1'b1;
                        state_d = HALTED;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end else begin
                    // A finished memory wait resolves the rest of the priority chain this cycle.
                    state_d = RUN;
                    if (m_halt) begin
                        pc_hold     = 1'b1;
                        hold_fd_raw = 1'b1;
                        hold_de_raw = 1'b1;
                        hold_em     = 1'b1;
                        hold_mw     = 1'b1;
                        state_d     = HALTED;
                    end else if (ex_br_taken) begin
                        flush_fd = 1'b1;
                        flush_de = 1'b1;
                    end else if (load_use) begin
                        pc_hold     = 1'b1;
                        hold_fd_raw = 1'b1;
                        flush_de    = 1'b1;
                    end else if (imem_busy) begin
                        pc_hold  = 1'b1;
                        flush_fd = 1'b1;
                    end
                end
            end
            HALTED: begin
                pc_hold     = 1'b1;
                hold_fd_raw = 1'b1;
                hold_de_raw = 1'b1;
                hold_em     = 1'b1;
                hold_mw     = 1'b1;
                halted      = 1'b1;
            end
        endcase
    end

    // A bubble always overrides recirculation on the same latch.
    assign hold_fd     = hold_fd_raw & ~flush_fd;
    assign hold_de     = hold_de_raw & ~flush_de;
    assign err_timeout = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= BOOT;
            boot_cnt_q <= '0;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

`ifdef PIPE_HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (pc_hold && (state_q == RUN || state_q == MEM_WAIT) && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + 1'b1;
        if (flush_de && flush_cnt_q != '1)
            flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized bench for pipe_hazard_ctrl against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;
    localparam int REG_W = 3, BOOT_CYCLES = 2, MEM_TIMEOUT = 64, CNT_W = 16;

    logic clk = 1'b0, rst = 1'b0;
    logic [REG_W-1:0] id_rs = '0, id_rt = '0, ex_rd = '0;
    logic id_use_rs = 0, id_use_rt = 0, ex_memread = 0, ex_br_taken = 0;
    logic imem_busy = 0, dmem_busy = 0, m_halt = 0;
    logic pc_hold, hold_fd, hold_de, hold_em, hold_mw, flush_fd, flush_de, halted, err_timeout;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_W(REG_W), .BOOT_CYCLES(BOOT_CYCLES), .MEM_TIMEOUT(MEM_TIMEOUT),
                       .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
        .id_use_rt(id_use_rt), .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_br_taken(ex_br_taken),
        .imem_busy(imem_busy), .dmem_busy(dmem_busy), .m_halt(m_halt), .pc_hold(pc_hold),
        .hold_fd(hold_fd), .hold_de(hold_de), .hold_em(hold_em), .hold_mw(hold_mw),
        .flush_fd(flush_fd), .flush_de(flush_de), .halted(halted), .err_timeout(err_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

    int n_chk = 0, n_fail = 0;

    // Model state: cycles of boot left, length of current dmem_busy run, frozen, sticky error.
    int boot_left, busy_run;
    bit frozen, err_m;
    int stall_m, flush_m;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Expected {pc_hold, hold_fd, hold_de, hold_em, hold_mw, flush_fd, flush_de, halted}
    function automatic logic [7:0] exp_out();
        bit lu;
        lu = ex_memread && ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
        if (!rst)               return 8'b1000_0100;
        if (frozen)             return 8'b1111_1001;
        if (boot_left > 0)      return 8'b1000_0100;
        if (dmem_busy)          return 8'b1111_1000;
        if (m_halt)             return 8'b1111_1000;
        if (ex_br_taken)        return 8'b0000_0110;
        if (lu)                 return 8'b1100_0010;
        if (imem_busy)          return 8'b1000_0100;
        return 8'b0;
    endfunction

    task automatic model_reset();
        boot_left = BOOT_CYCLES; busy_run = 0; frozen = 0; err_m = 0;
        stall_m = 0; flush_m = 0;
    endtask

    task automatic check_all(input string tag);
        logic [7:0] e;
        e = exp_out();
        chk({tag, ".outs"}, {24'd0, pc_hold, hold_fd, hold_de, hold_em, hold_mw,
                             flush_fd, flush_de, halted}, {24'd0, e});
        chk({tag, ".err"}, {31'd0, err_timeout}, {31'd0, err_m});
`ifdef PIPE_HAZARD_PERF_EN
        chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(stall_m));
        chk({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(flush_m));
`else
        chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'd0);
        chk({tag, ".flush_cnt"}, 32'(flush_cnt), 32'd0);
`endif
    endtask

    task automatic model_step();
        logic [7:0] e;
        e = exp_out();
        if (!rst) return;
        if (!frozen && boot_left == 0) begin
            if (e[7] && stall_m < (1 << CNT_W) - 1) stall_m++;
            if (e[1] && flush_m < (1 << CNT_W) - 1) flush_m++;
        end
        if (frozen) begin
        end else if (boot_left > 0) begin
            boot_left--;
        end else if (dmem_busy) begin
            busy_run++;
            if (busy_run >= MEM_TIMEOUT) begin frozen = 1; err_m = 1; end
        end else begin
            busy_run = 0;
            if (m_halt) frozen = 1;
        end
    endtask

    // Inputs are set before the call; check mid-cycle, then advance model on the edge.
    task automatic cycle(input string tag);
        @(negedge clk);
        check_all(tag);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        id_rs = '0; id_rt = '0; ex_rd = '0; id_use_rs = 0; id_use_rt = 0;
        ex_memread = 0; ex_br_taken = 0; imem_busy = 0; dmem_busy = 0; m_halt = 0;
    endtask

    task automatic rand_inputs();
        id_rs = REG_W'($urandom); id_rt = REG_W'($urandom); ex_rd = REG_W'($urandom);
        id_use_rs = 1'($urandom); id_use_rt = 1'($urandom);
        ex_memread = 1'($urandom); ex_br_taken = ($urandom_range(0, 3) == 0);
        imem_busy = ($urandom_range(0, 3) == 0); dmem_busy = ($urandom_range(0, 4) == 0);
        m_halt = ($urandom_range(0, 149) == 0);
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        idle_inputs();
        cycle("in_rst");
        cycle("in_rst");
        rst = 1'b1;
    endtask

    initial begin
        model_reset();
        idle_inputs();
        @(posedge clk); #1;
        apply_reset();
        repeat (4) cycle("boot");

        ex_memread = 1; ex_rd = 3'd3; id_rs = 3'd3; id_use_rs = 1;
        cycle("load_use");
        idle_inputs();
        cycle("after_lu");

        ex_memread = 1; ex_rd = 3'd3; id_rs = 3'd3; id_use_rs = 1; ex_br_taken = 1;
        cycle("lu_br");
        idle_inputs();
        ex_memread = 1; ex_rd = 3'd0; id_rt = 3'd0; id_use_rt = 1;
        cycle("lu_r0");
        idle_inputs();
        imem_busy = 1;
        cycle("imem");
        idle_inputs();

        dmem_busy = 1;
        repeat (5) cycle("dmem5");
        dmem_busy = 0;
        repeat (2) cycle("dmem_rel");

        dmem_busy = 1; m_halt = 1;
        cycle("dmem_halt");
        dmem_busy = 0;
        cycle("wait_to_halt");
        m_halt = 0;
        repeat (3) cycle("halted");

        apply_reset();
        repeat (3) cycle("boot2");
        dmem_busy = 1;
        repeat (MEM_TIMEOUT) cycle("dmem_to");
        dmem_busy = 0;
        repeat (4) cycle("to_sticky");
        chk("to_err", {31'd0, err_timeout}, 32'd1);
        chk("to_halted", {31'd0, halted}, 32'd1);

        for (int ep = 0; ep < 5; ep++) begin
            apply_reset();
            repeat (250) begin
                rand_inputs();
                cycle("rand");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
